seg7_to_bcd_capture: RTL
========================

// Module: seg7_to_bcd_capture
// PURPOSE
//   Inverse of the display encoder: monitors multiplexed 7-segment display lines
//   (segments plus one-hot digit select) and recovers the BCD value of every digit.
//   A digit is captured only after segments and select have been stable for a
//   programmable number of cycles.
//   Used as on-chip display readback/self-check and as a bench monitor for the clock.
// PARAMETERS
//   NUM_DIGITS     6   number of multiplexed digits (digit-select width)
//   STABLE_CYCLES  4   consecutive stable sampled cycles required before capture (>=1)
// PORTS
//   i_clk          in   1               system clock, rising edge
//   i_rst_n        in   1               asynchronous, active-low reset
//   i_ena          in   1               capture enable; low = FSM forced to IDLE, outputs held
//   i_seg          in   7               segments, bit6=a .. bit0=g, 1 = lit
//   i_dig_sel      in   NUM_DIGITS      digit select, bit n = digit n, one-hot when valid
//   o_bcd          out  4*NUM_DIGITS    digit n at [4n+3:4n]; 4'hF = blank/invalid
//   o_digit_valid  out  NUM_DIGITS      bit n = last capture of digit n was a legal 0-9
//   o_frame        out  1               1-cycle pulse: every digit captured since last pulse
//   o_err          out  1               1-cycle pulse: captured pattern was not 0-9 or blank
// BEHAVIOUR
//   Reset (async, immediate, also mid-capture):
//     o_bcd = all 4'hF, o_digit_valid = 0, o_frame = 0, o_err = 0
//     FSM = IDLE, stability counter = 0, seen-mask = 0, input sample regs = 0
//   Input stage: i_seg/i_dig_sel registered once (s_seg, s_sel); FSM uses only registered copies.
//   "Changed" = s_seg or s_sel differs from its value one cycle earlier.
//   FSM states:
//     IDLE   -> SETTLE (cnt=1) when i_ena=1 and s_sel exactly one-hot; else stay
//     SETTLE -> unchanged and one-hot: cnt+1; reaching STABLE_CYCLES writes digit -> HOLD
//            -> changed: to SETTLE (cnt=1) if new s_sel one-hot, else IDLE
//     HOLD   -> no rewrite while unchanged; changed: same rule as SETTLE
//     Any state with i_ena=0 -> IDLE, cnt=0; registered outputs hold their values
//   Zero or multi-hot s_sel is never captured.
//   Latency: inputs held constant -> o_bcd updated after STABLE_CYCLES+1 rising edges,
//     counted from the first edge that samples them (STABLE_CYCLES=1 -> 2 edges).
//   Capture write, digit idx = index of the set bit in s_sel:
//     7E->0 30->1 6D->2 79->3 33->4 5B->5 5F->6 70->7 7F->8 7B->9 : o_bcd[idx]=value, valid[idx]=1
//     00 (blank)  : o_bcd[idx]=4'hF, valid[idx]=0, no error
//     other       : o_bcd[idx]=4'hF, valid[idx]=0, o_err=1 for exactly one cycle
//   Frame tracking: seen-mask bit idx set on each capture, including blank/error.
//     When a capture completes an all-ones mask: o_frame=1 in the same cycle the final
//       digit's o_bcd becomes visible; mask cleared that edge.
//     Recapture of an already-seen digit only re-sets its bit; no frame pulse.
//   o_err and o_frame may pulse in the same cycle; one capture max per cycle.
// TESTING
//   1. Reset: o_bcd all F, valid 0; digit 2 + 7B held 5 edges -> o_bcd[11:8]=9,
//      valid[2]=1, at edge 5 exactly.
//   2. Glitch reject: digit 0 with 30 for 3 edges, then 7E -> counter restarts;
//      only 0 ever written to digit 0.
//   3. Blank and illegal: digit 1 with 00 -> F, no err; digit 1 with 01 -> F, valid[1]=0,
//      o_err pulses 1 cycle.
//   4. Select faults: i_dig_sel 000000 or 000011 held 20 cycles -> no writes, no err/frame.
//   5. Full scan: digits 0..5 show 1,2,3,4,5,6, each 6 cycles -> o_bcd=0x654321,
//      one o_frame pulse with digit 5 write; repeat scan -> second pulse.
//   6. Reset mid-SETTLE, and i_ena low mid-SETTLE -> no capture;
//      ena low holds o_bcd; after ena high, full STABLE_CYCLES+1 needed.

Source files
------------

// File: rtl/seg7_to_bcd_capture.sv
// Recovers per-digit BCD values from multiplexed 7-segment display lines.
// A digit is written only after segments and select stay stable for STABLE_CYCLES samples.
module seg7_to_bcd_capture #(
    parameter int unsigned NUM_DIGITS    = 6,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_ena,
    input  logic [6:0]              i_seg,
    input  logic [NUM_DIGITS-1:0]   i_dig_sel,
    output logic [4*NUM_DIGITS-1:0] o_bcd,
    output logic [NUM_DIGITS-1:0]   o_digit_valid,
    output logic                    o_frame,
    output logic                    o_err
);

    localparam int unsigned SEG_W  = 7;
    localparam int unsigned BCD_W  = 4;
    localparam int unsigned CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam bit SINGLE = (STABLE_CYCLES == 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [SEG_W-1:0]          seg_q, seg_prev_q;
    logic [NUM_DIGITS-1:0]     sel_q, sel_prev_q;
    logic [NUM_DIGITS-1:0]     seen_q, seen_d;
    logic [4*NUM_DIGITS-1:0]   bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]     valid_q, valid_d;
    logic                      frame_q, frame_d;
    logic                      err_q, err_d;

    logic                      sel_onehot;
    logic                      changed;
    logic                      capture;
    logic                      restart;
    logic [BCD_W-1:0]          dec;
    logic [NUM_DIGITS-1:0]     seen_next;

    // Segment pattern to BCD; 4'hF marks blank or unrecognised patterns
    function automatic logic [3:0] seg_to_bcd(input logic [6:0] seg);
        logic [3:0] val;
        case (seg)
            7'h7E:   val = 4'd0;
            7'h30:   val = 4'd1;
            7'h6D:   val = 4'd2;
            7'h79:   val = 4'd3;
            7'h33:   val = 4'd4;
            7'h5B:   val = 4'd5;
            7'h5F:   val = 4'd6;
            7'h70:   val = 4'd7;
            7'h7F:   val = 4'd8;
            7'h7B:   val = 4'd9;
            default: val = 4'hF;
        endcase
        return val;
    endfunction

    assign sel_onehot = (sel_q != '0) && ((sel_q & (sel_q - NUM_DIGITS'(1))) == '0);
    assign changed    = (seg_q != seg_prev_q) || (sel_q != sel_prev_q);
    assign dec        = seg_to_bcd(seg_q);
    assign seen_next  = seen_q | sel_q;

    // Stability FSM: restart on any change, capture once the count reaches STABLE_CYCLES
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        restart = 1'b0;
        if (!i_ena) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sel_onehot) restart = 1'b1;
                end
                ST_SETTLE: begin
                    if (changed || !sel_onehot) begin
                        if (sel_onehot) begin
                            restart = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end
                    end else if ((cnt_q + CNT_ONE) >= CNT_MAX) begin
                        capture = 1'b1;
                        state_d = ST_HOLD;
                        cnt_d   = CNT_MAX;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_HOLD: begin
                    if (changed) begin
                        if (sel_onehot) begin
                            restart = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
            if (restart) begin
                cnt_d = CNT_ONE;
                if (SINGLE) begin
                    capture = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
        end
    end

    // Capture write, error flag and frame tracking
    always_comb begin
        bcd_d   = bcd_q;
        valid_d = valid_q;
        seen_d  = seen_q;
        frame_d = 1'b0;
        err_d   = 1'b0;
        if (capture) begin
            for (int unsigned n = 0; n < NUM_DIGITS; n++) begin
                if (sel_q[n]) begin
                    bcd_d[BCD_W*n +: BCD_W] = dec;
                    valid_d[n]              = (dec != 4'hF);
                end
            end
            err_d = (dec == 4'hF) && (seg_q != '0);
            if (&seen_next) begin
                frame_d = 1'b1;
                seen_d  = '0;
            end else begin
                seen_d = seen_next;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            seg_q      <= '0;
            seg_prev_q <= '0;
            sel_q      <= '0;
            sel_prev_q <= '0;
            seen_q     <= '0;
            bcd_q      <= '1;
            valid_q    <= '0;
            frame_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seg_q      <= i_seg;
            seg_prev_q <= seg_q;
            sel_q      <= i_dig_sel;
            sel_prev_q <= sel_q;
            seen_q     <= seen_d;
            bcd_q      <= bcd_d;
            valid_q    <= valid_d;
            frame_q    <= frame_d;
            err_q      <= err_d;
        end
    end

    assign o_bcd         = bcd_q;
    assign o_digit_valid = valid_q;
    assign o_frame       = frame_q;
    assign o_err         = err_q;

endmodule
